sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
- Shares the single byte-wide SDRAM port between three requesters:
  - the ioctl loader, which writes cassette/cartridge images;
  - the cassette reader;
  - a cartridge ROM fetch path.
- Sits between the requesters and the sdram controller and replaces the current addr/we mux.
- Serialises one access at a time and waits a fixed latency for read data.
- Returns read data and a one-cycle acknowledge to the winning requester.

Parameters:
- AW, 25, SDRAM byte address width.
- RD_LAT, 4, cycles from the sd_rd pulse to sd_dout being valid (range 1..15).
- WR_LAT, 2, recovery cycles after an sd_we pulse before the next access (range 1..15).

Ports:
- clk  in  1  system clock (clk_sys domain).
- reset  in  1  asynchronous active-low reset.
- ld_req  in  1  loader write request; level, held until ld_ack.
- ld_addr  in  AW  loader write address.
- ld_data  in  8  loader write data.
- ld_ack  out  1  one-cycle pulse: write complete.
- cas_req  in  1  cassette read request; level, held until cas_ack.
- cas_addr  in  AW  cassette read address.
- cas_ack  out  1  one-cycle pulse: cas_data valid.
- cas_data  out  8  cassette read data; held until the next cas_ack.
- crt_req  in  1  cartridge read request; level, held until crt_ack.
- crt_addr  in  AW  cartridge read address.
- crt_ack  out  1  one-cycle pulse: crt_data valid.
- crt_data  out  8  cartridge read data; held until the next crt_ack.
- sd_addr  out  AW  address to sdram.
- sd_din  out  8  write data to sdram.
- sd_rd  out  1  one-cycle read strobe.
- sd_we  out  1  one-cycle write strobe.
- sd_dout  in  8  read data from sdram.
- busy  out  1  high in every state except IDLE.
- grant  out  2  current owner: 0 none, 1 loader, 2 cassette, 3 cartridge.

Behaviour:

Reset:
- Asynchronous assertion; the block leaves reset on the first clk edge after deassertion.
- All outputs are 0: sd_addr, sd_din, cas_data, crt_data, acks, strobes, busy, grant.
- State goes to IDLE and the round-robin pointer points to cassette.
- Reset mid-access abandons the access: no ack is issued and the data registers clear.

States: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.

IDLE:
- Samples the req lines.
- Arbitration:
  - ld_req has fixed highest priority.
  - Cassette and cartridge are round-robin: if both request, the one not served most recently wins. The pointer updates only when one of them is granted.
- On a winner: latch grant and latch the address (and ld_data for the loader) into sd_addr/sd_din, then go to ISSUE.
- With no request: stay in IDLE, grant=0.

ISSUE (one cycle):
- Assert sd_we (loader) or sd_rd (read) for exactly this cycle.
- Load the wait counter with WR_LAT or RD_LAT, then go to WAIT.

WAIT:
- Decrement the counter each cycle.
- When it reaches 1: for a read, capture sd_dout into the owner's data register, then go to DONE.

DONE (one cycle):
- Pulse the owner's ack; the data register is already valid in this cycle.
- Clear grant and return to IDLE.
- Requesters must drop or renew req in the cycle after ack. Because DONE cannot re-arbitrate, the earliest re-grant is the IDLE cycle that follows.

Timing and stability:
- Read latency, req rise to ack (req sampled in IDLE): RD_LAT+2 cycles. Write latency: WR_LAT+2.
- Back-to-back period for one requester: RD_LAT+3 cycles.
- sd_addr and sd_din stay stable from ISSUE through DONE and are held afterwards until the next grant.
- The block never asserts sd_rd and sd_we together; at most one strobe per access.

Boundary conditions:
- A req that drops before grant is simply not serviced.
- A req that drops after grant still completes the access and still acks.
- Requester addr/data inputs are ignored after latching.
- A loader request arriving mid-access waits for DONE, then wins at the next IDLE.
- The cassette/cartridge pointer is unaffected by loader grants.
- Address values pass through unmodified; no wrap handling. All-ones is a legal address.

Test Plan:
1. Reset with RD_LAT=4; cas_req=1, cas_addr=0x000123, sd_dout model returns 0x5A four cycles after sd_rd. Required: sd_rd is one pulse with sd_addr=0x000123; cas_ack occurs 6 cycles after cas_req is sampled; cas_data=0x5A, held after ack; grant=2 during the access.
2. ld_req=1, ld_addr=0x1FFFFFF, ld_data=0xC3, WR_LAT=2. Required: one sd_we pulse with sd_din=0xC3 and sd_addr=0x1FFFFFF; ld_ack occurs 4 cycles after sampling; sd_rd never asserted.
3. cas_req and crt_req held high for 4 accesses. Required grant order 2,3,2,3; each ack reaches only its owner; crt_data and cas_data each hold their own read values.
4. ld_req, cas_req and crt_req all rise in the same IDLE cycle. Required: loader served first; then cassette (pointer at reset); the pointer is not disturbed by the loader grant.
5. ld_req rises during a cassette WAIT. Required: the cassette access completes and cas_ack fires; the loader is granted at the next IDLE with no extra gap.
6. reset asserted in WAIT of a cartridge read. Required: all outputs become 0 asynchronously; no crt_ack; after release, a fresh crt_req is serviced normally with grant=3.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
// Shares the byte-wide SDRAM port between the ioctl loader (writes), the
// cassette reader and the cartridge ROM fetch path (reads). One access runs
// at a time: IDLE arbitrates, ISSUE strobes, WAIT counts out the fixed
// latency, DONE acknowledges the owner.

module sdram_port_arbiter #(
    parameter int AW     = 25,
    parameter int RD_LAT = 4,   // sd_rd pulse to valid sd_dout, 1..15
    parameter int WR_LAT = 2    // recovery after sd_we pulse, 1..15
) (
    input  logic          clk,
    input  logic          reset,      // asynchronous, active low

    input  logic          ld_req,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_data,
    output logic          ld_ack,

    input  logic          cas_req,
    input  logic [AW-1:0] cas_addr,
    output logic          cas_ack,
    output logic [7:0]    cas_data,

    input  logic          crt_req,
    input  logic [AW-1:0] crt_addr,
    output logic          crt_ack,
    output logic [7:0]    crt_data,

    output logic [AW-1:0] sd_addr,
    output logic [7:0]    sd_din,
    output logic          sd_rd,
    output logic          sd_we,
    input  logic [7:0]    sd_dout,

    output logic          busy,
    output logic [1:0]    grant
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_LD   = 2'd1;
    localparam logic [1:0] G_CAS  = 2'd2;
    localparam logic [1:0] G_CRT  = 2'd3;

    localparam logic [3:0] RD_CNT = RD_LAT[3:0];
    localparam logic [3:0] WR_CNT = WR_LAT[3:0];

    state_t     state;
    state_t     state_next;
    logic [1:0] winner;
    logic [3:0] wait_cnt;
    logic       rr_crt;     // 1: cartridge wins the next cas/crt tie

    // Arbitration and next-state decode.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_next = state;
        winner     = G_NONE;

        if (ld_req)
            winner = G_LD;
        else if (cas_req && crt_req)
            winner = rr_crt ? G_CRT : G_CAS;
        else if (cas_req)
            winner = G_CAS;
        else if (crt_req)
            winner = G_CRT;

        case (state)
            S_IDLE:  if (winner != G_NONE) state_next = S_ISSUE;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  if (wait_cnt == 4'd1) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Strobes, acks and busy are decoded from registered state and owner.
    always_comb begin
        sd_rd   = (state == S_ISSUE) && (grant != G_LD);
        sd_we   = (state == S_ISSUE) && (grant == G_LD);
        ld_ack  = (state == S_DONE)  && (grant == G_LD);
        cas_ack = (state == S_DONE)  && (grant == G_CAS);
        crt_ack = (state == S_DONE)  && (grant == G_CRT);
        busy    = (state != S_IDLE);
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // Owner, address/data latches, latency counter, read data capture and
    // the round-robin pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant    <= G_NONE;
            sd_addr  <= '0;
            sd_din   <= '0;
            cas_data <= '0;
            crt_data <= '0;
            wait_cnt <= '0;
            rr_crt   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    grant <= winner;
                    case (winner)
                        G_LD: begin
                            sd_addr <= ld_addr;
                            sd_din  <= ld_data;
                        end
                        G_CAS: begin
                            sd_addr <= cas_addr;
                            rr_crt  <= 1'b1;
                        end
                        G_CRT: begin
                            sd_addr <= crt_addr;
                            rr_crt  <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                S_ISSUE: begin
                    wait_cnt <= (grant == G_LD) ? WR_CNT : RD_CNT;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        if (grant == G_CAS) cas_data <= sd_dout;
                        if (grant == G_CRT) crt_data <= sd_dout;
                    end
                end
                S_DONE: begin
                    grant <= G_NONE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: a table of single-access vectors followed by
// hand-written sequences for loader pre-emption, mid-access reset, three-way
// contention and back-to-back round-robin.

module tb_sdram_port_arbiter;

    localparam int AW     = 25;
    localparam int RD_LAT = 4;
    localparam int WR_LAT = 2;

    logic          clk;
    logic          reset;
    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic [7:0]    ld_data;
    logic          ld_ack;
    logic          cas_req;
    logic [AW-1:0] cas_addr;
    logic          cas_ack;
    logic [7:0]    cas_data;
    logic          crt_req;
    logic [AW-1:0] crt_addr;
    logic          crt_ack;
    logic [7:0]    crt_data;
    logic [AW-1:0] sd_addr;
    logic [7:0]    sd_din;
    logic          sd_rd;
    logic          sd_we;
    logic [7:0]    sd_dout;
    logic          busy;
    logic [1:0]    grant;

    int n_cmp  = 0;
    int n_fail = 0;

    sdram_port_arbiter #(.AW(AW), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
        .clk      (clk),
        .reset    (reset),
        .ld_req   (ld_req),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .ld_ack   (ld_ack),
        .cas_req  (cas_req),
        .cas_addr (cas_addr),
        .cas_ack  (cas_ack),
        .cas_data (cas_data),
        .crt_req  (crt_req),
        .crt_addr (crt_addr),
        .crt_ack  (crt_ack),
        .crt_data (crt_data),
        .sd_addr  (sd_addr),
        .sd_din   (sd_din),
        .sd_rd    (sd_rd),
        .sd_we    (sd_we),
        .sd_dout  (sd_dout),
        .busy     (busy),
        .grant    (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SDRAM read model: byte = addr[7:0] + 0x37, valid only in the cycle
    // RD_LAT cycles after the sd_rd cycle; filler value otherwise.
    int            rd_cd = 0;
    logic [AW-1:0] rd_a  = '0;
    initial sd_dout = 8'hEE;
    always @(negedge clk) begin
        if (sd_rd) begin
            rd_cd   = RD_LAT;
            rd_a    = sd_addr;
            sd_dout = 8'hEE;
        end else if (rd_cd > 0) begin
            rd_cd   = rd_cd - 1;
            sd_dout = (rd_cd == 0) ? (rd_a[7:0] + 8'h37) : 8'hEE;
        end else begin
            sd_dout = 8'hEE;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " sd_addr"},  32'(sd_addr), 0);
        check({tag, " sd_din"},   32'(sd_din), 0);
        check({tag, " cas_data"}, 32'(cas_data), 0);
        check({tag, " crt_data"}, 32'(crt_data), 0);
        check({tag, " acks"},     32'({ld_ack, cas_ack, crt_ack}), 0);
        check({tag, " strobes"},  32'({sd_rd, sd_we}), 0);
        check({tag, " busy"},     32'(busy), 0);
        check({tag, " grant"},    32'(grant), 0);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy && k < 30) begin
            @(negedge clk);
            k++;
        end
        check({tag, " idle"}, 32'(busy), 0);
    endtask

    // Called at a negedge while the DUT is in IDLE with the winner's req set;
    // returns at the negedge of the DONE cycle.
    task automatic observe(input string tag, input logic [1:0] eg, input logic [AW-1:0] ea,
                           input logic wr, input logic [7:0] ed, input int elat,
                           input int ld_rise);
        int   n, rd_c, we_c, oth, gbad, ack_n;
        logic own;
        n = 0; rd_c = 0; we_c = 0; oth = 0; gbad = 0; ack_n = -1;
        while (n < 40 && ack_n < 0) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check({tag, " sd_addr@issue"}, 32'(sd_addr), 32'(ea));
                check({tag, " busy@issue"}, 32'(busy), 1);
                // Owner inputs change after latching; the DUT must ignore them.
                case (eg)
                    2'd1: begin ld_addr = ~ld_addr; ld_data = ~ld_data; end
                    2'd2: cas_addr = ~cas_addr;
                    2'd3: crt_addr = ~crt_addr;
                    default: ;
                endcase
            end
            if (grant !== eg) gbad++;
            rd_c += int'(sd_rd);
            we_c += int'(sd_we);
            own = (eg == 2'd1) ? ld_ack : (eg == 2'd2) ? cas_ack : crt_ack;
            if ((ld_ack | cas_ack | crt_ack) && !own) oth++;
            if (n == ld_rise) begin
                ld_req  = 1'b1;
                ld_addr = 25'h0000ABC;
                ld_data = 8'h99;
            end
            if (own) begin
                ack_n = n;
                check({tag, " sd_addr@ack"}, 32'(sd_addr), 32'(ea));
                if (wr)
                    check({tag, " sd_din@ack"}, 32'(sd_din), 32'(ed));
                else
                    check({tag, " rdata@ack"}, 32'((eg == 2'd2) ? cas_data : crt_data), 32'(ed));
            end
        end
        check({tag, " latency"}, 32'(ack_n), 32'(elat));
        check({tag, " grant"}, 32'(gbad), 0);
        check({tag, " sd_rd pulses"}, 32'(rd_c), wr ? 0 : 1);
        check({tag, " sd_we pulses"}, 32'(we_c), wr ? 1 : 0);
        check({tag, " foreign ack"}, 32'(oth), 0);
    endtask

    typedef struct {
        logic          ld, cas, crt;
        logic [AW-1:0] ld_a, cas_a, crt_a;
        logic [7:0]    ld_d;
        logic [1:0]    eg;
        logic [AW-1:0] ea;
        logic          wr;
        logic [7:0]    ed;
        int            elat;
    } vec_t;

    vec_t vecs [9];

    initial begin
        // Read data = addr[7:0] + 0x37; read latency 6, write latency 4.
        vecs[0] = '{1'b0, 1'b1, 1'b0, 25'h0, 25'h0000123, 25'h0, 8'h00, 2'd2, 25'h0000123, 1'b0, 8'h5A, 6};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 25'h1FFFFFF, 25'h0, 25'h0, 8'hC3, 2'd1, 25'h1FFFFFF, 1'b1, 8'hC3, 4};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 25'h0, 25'h0000010, 25'h0ABCDE0, 8'h00, 2'd3, 25'h0ABCDE0, 1'b0, 8'h17, 6};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 25'h0, 25'h0000010, 25'h0000020, 8'h00, 2'd2, 25'h0000010, 1'b0, 8'h47, 6};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 25'h0, 25'h0, 25'h1000000, 8'h00, 2'd3, 25'h1000000, 1'b0, 8'h37, 6};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 25'h0, 25'h0000055, 25'h0000066, 8'h81, 2'd1, 25'h0000000, 1'b1, 8'h81, 4};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 25'h0, 25'h1FFFFFF, 25'h0000077, 8'h00, 2'd2, 25'h1FFFFFF, 1'b0, 8'h36, 6};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 25'h0, 25'h0000080, 25'h0, 8'h00, 2'd2, 25'h0000080, 1'b0, 8'hB7, 6};
        vecs[8] = '{1'b1, 1'b0, 1'b1, 25'h0000400, 25'h0, 25'h0000010, 8'h3C, 2'd1, 25'h0000400, 1'b1, 8'h3C, 4};

        reset = 1'b0;
        ld_req = 1'b0; cas_req = 1'b0; crt_req = 1'b0;
        ld_addr = '0; ld_data = '0; cas_addr = '0; crt_addr = '0;

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        @(negedge clk);

        // Single-access vectors.
        for (int i = 0; i < 9; i++) begin
            wait_idle($sformatf("v%0d", i));
            ld_req   = vecs[i].ld;
            cas_req  = vecs[i].cas;
            crt_req  = vecs[i].crt;
            ld_addr  = vecs[i].ld_a;
            ld_data  = vecs[i].ld_d;
            cas_addr = vecs[i].cas_a;
            crt_addr = vecs[i].crt_a;
            observe($sformatf("v%0d", i), vecs[i].eg, vecs[i].ea, vecs[i].wr,
                    vecs[i].ed, vecs[i].elat, -1);
            ld_req = 1'b0; cas_req = 1'b0; crt_req = 1'b0;
            @(negedge clk);
            check($sformatf("v%0d ack pulse width", i), 32'({ld_ack, cas_ack, crt_ack}), 0);
            if (!vecs[i].wr)
                check($sformatf("v%0d data held", i),
                      32'((vecs[i].eg == 2'd2) ? cas_data : crt_data), 32'(vecs[i].ed));
        end

        // Loader request arriving during a cassette WAIT.
        wait_idle("t5");
        cas_req  = 1'b1;
        cas_addr = 25'h0000500;
        observe("t5 cas", 2'd2, 25'h0000500, 1'b0, 8'h37, 6, 3);
        cas_req = 1'b0;
        @(negedge clk);
        observe("t5 ld", 2'd1, 25'h0000ABC, 1'b1, 8'h99, 4, -1);
        ld_req = 1'b0;
        @(negedge clk);

        // Reset during the WAIT of a cartridge read.
        wait_idle("t6");
        crt_req  = 1'b1;
        crt_addr = 25'h0000042;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1 check_all_zero("t6 async");
        crt_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("t6 no crt_ack", 32'({crt_ack, busy}), 0);
        end
        crt_req  = 1'b1;
        crt_addr = 25'h0000099;
        observe("t6 fresh", 2'd3, 25'h0000099, 1'b0, 8'hD0, 6, -1);
        crt_req = 1'b0;
        @(negedge clk);

        // Clean reset, then all three requesters in the same IDLE cycle.
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        ld_req = 1'b1;  ld_addr = 25'h0000200; ld_data = 8'hA5;
        cas_req = 1'b1; cas_addr = 25'h0000301;
        crt_req = 1'b1; crt_addr = 25'h0000402;
        observe("t4 ld", 2'd1, 25'h0000200, 1'b1, 8'hA5, 4, -1);
        ld_req = 1'b0;
        @(negedge clk);
        observe("t4 cas", 2'd2, 25'h0000301, 1'b0, 8'h38, 6, -1);
        cas_req = 1'b0;
        @(negedge clk);
        observe("t4 crt", 2'd3, 25'h0000402, 1'b0, 8'h39, 6, -1);
        crt_req = 1'b0;
        @(negedge clk);

        // Cassette and cartridge held high for four back-to-back accesses.
        wait_idle("t3");
        cas_req = 1'b1; cas_addr = 25'h0001000;
        crt_req = 1'b1; crt_addr = 25'h0002011;
        observe("t3 a1", 2'd2, 25'h0001000, 1'b0, 8'h37, 6, -1);
        cas_addr = 25'h0001022;
        @(negedge clk);
        observe("t3 a2", 2'd3, 25'h0002011, 1'b0, 8'h48, 6, -1);
        crt_addr = 25'h0002033;
        @(negedge clk);
        observe("t3 a3", 2'd2, 25'h0001022, 1'b0, 8'h59, 6, -1);
        @(negedge clk);
        observe("t3 a4", 2'd3, 25'h0002033, 1'b0, 8'h6A, 6, -1);
        cas_req = 1'b0; crt_req = 1'b0;
        @(negedge clk);
        check("t3 cas_data held", 32'(cas_data), 32'h59);
        check("t3 crt_data held", 32'(crt_data), 32'h6A);
        repeat (2) @(negedge clk);
        check("t3 idle grant", 32'({busy, grant}), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
